// File: rtl/shift_add_mac.sv
// Sequential shift-add multiply-accumulator: D = Q*M + R, one quotient bit per clock.
// Companion of the non-restoring divider, used for reconstruction and as a plain multiplier.
module shift_add_mac #(
  parameter int QW = 4,
  parameter int MW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [QW-1:0]    Q,
  input  logic [MW-1:0]    M,
  input  logic [MW-1:0]    R,
  output logic [QW+MW-1:0] D,
  output logic             busy,
  output logic             done
);

  localparam int DW = QW + MW;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   acc_reg, acc_next;
  logic [DW-1:0]   d_reg, d_next;
  logic [MW-1:0]   m_reg, m_next;
  logic [QW-1:0]   q_reg, q_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done_reg, done_next;
  logic [DW-1:0]   addend;
  logic [DW-1:0]   sum;

  // Partial product for the current quotient bit; the DW-wide accumulator cannot overflow.
  assign addend = DW'(m_reg) << cnt_reg;
  assign sum    = q_reg[0] ? (acc_reg + addend) : acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      d_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      d_reg     <= d_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    d_next     = d_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = DW'(R);
          m_next     = M;
          q_next     = Q;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        acc_next = sum;
        q_next   = q_reg >> 1;
        cnt_next = cnt_reg + 1'b1;
        // Final step publishes this edge's sum directly so D never shows a partial value.
        if (cnt_reg == LAST) begin
          d_next     = sum;
          done_next  = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign D    = d_reg;
  assign busy = (state_reg == CALC);
  assign done = done_reg;

endmodule

// File: tb/tb_shift_add_mac.sv
// Self-checking bench for shift_add_mac: cycle-level behavioural model plus directed
// literal checks and a randomized phase.
module tb_shift_add_mac;
  localparam int QW = 4;
  localparam int MW = 5;
  localparam int DW = QW + MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [QW-1:0] Q;
  logic [MW-1:0] M;
  logic [MW-1:0] R;
  logic [DW-1:0] D;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  shift_add_mac #(.QW(QW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .Q(Q), .M(M), .R(R),
    .D(D), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: an accepted request yields Q*M+R exactly QW edges later.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_d = '0;
  logic [DW-1:0] m_pending = '0;
  int            m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_d    <= '0;
      m_left <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy    <= 1'b1;
        m_pending <= DW'(Q) * DW'(M) + DW'(R);
        m_left    <= QW;
      end
    end else begin
      m_done <= 1'b0;
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_d    <= m_pending;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_D", 32'(D), 32'(m_d));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
    end
  end

  // Pulse start with the given operands and check latency, busy length and result.
  task automatic run_op(input logic [QW-1:0] q, input logic [MW-1:0] m,
                        input logic [MW-1:0] r, input logic [DW-1:0] exp_d);
    int n;
    int bc;
    start = 1'b1; Q = q; M = m; R = r;
    n = 0; bc = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy) bc++;
    end while (!done && n < 20);
    check("op_done_seen", 32'(done), 32'd1);
    check("op_latency", 32'(n), 32'(QW + 1));
    check("op_busy_cycles", 32'(bc), 32'(QW));
    check("op_D", 32'(D), 32'(exp_d));
    $display("[TB] op Q=%0d M=%0d R=%0d -> D=%0d (edges=%0d)", q, m, r, D, n);
  endtask

  initial begin
    int pulses;
    int n;
    bit prev_done;

    rst = 1'b1; start = 1'b1; Q = 4'hF; M = 5'd31; R = 5'd31;
    @(negedge clk);
    check_en = 1'b1;
    check("rst_D_1", 32'(D), 32'd0);
    check("rst_busy_1", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_D_2", 32'(D), 32'd0);
    check("rst_busy_2", 32'(busy), 32'd0);
    check("rst_done_2", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);

    run_op(4'd1, 5'b01011, 5'd4, 9'd15);
    run_op(4'd15, 5'd31, 5'd31, 9'd496);
    run_op(4'd0, 5'd11, 5'd7, 9'd7);
    run_op(4'd13, 5'd0, 5'd9, 9'd9);

    // Request arriving while busy must wait for the post-done edge.
    start = 1'b1; Q = 4'd3; M = 5'd10; R = 5'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; Q = 4'd15; M = 5'd31; R = 5'd31;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("ign_first_done", 32'(done), 32'd1);
    check("ign_first_D", 32'(D), 32'd30);
    $display("[TB] op Q=3 M=10 R=0 (second request pending) -> D=%0d", D);
    @(negedge clk);
    start = 1'b0;
    check("ign_accept_busy", 32'(busy), 32'd1);
    check("ign_accept_D_hold", 32'(D), 32'd30);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("ign_second_D", 32'(D), 32'd496);
    $display("[TB] op Q=15 M=31 R=31 (accepted after done) -> D=%0d", D);

    // Back-to-back with start held high.
    start = 1'b1; Q = 4'd2; M = 5'd7; R = 5'd1;
    pulses = 0; prev_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("b2b_D", 32'(D), 32'd15);
        $display("[TB] b2b op Q=2 M=7 R=1 -> D=%0d at cycle %0d", D, i);
      end
      if (done && prev_done) check("b2b_no_double_done", 32'd1, 32'd0);
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd4);
    @(negedge clk);

    // Reset during the second compute edge discards the operation.
    start = 1'b1; Q = 4'd15; M = 5'd31; R = 5'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_D", 32'(D), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    $display("[TB] op Q=15 M=31 R=0 aborted by reset -> D=%0d", D);
    run_op(4'd15, 5'd31, 5'd0, 9'd465);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      Q = QW'($urandom);
      M = MW'($urandom);
      R = MW'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      if (done) $display("[TB] random op completed -> D=%0d (model %0d)", D, m_d);
    end
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
